// File: rtl/wddl_decoder_pkg.sv
// Shared types and constants for the WDDL receive-end decoder.
package wddl_decoder_pkg;

  localparam int unsigned DEF_WIDTH     = 128;
  localparam int unsigned DEF_ERR_CNT_W = 16;

  // Bit positions inside err_out
  localparam int unsigned ERR_EVAL  = 0;
  localparam int unsigned ERR_PRECH = 1;
  localparam int unsigned ERR_OVF   = 2;
  localparam int unsigned ERR_W     = 3;

  typedef enum logic [1:0] {
    WAIT_PRE = 2'd0,
    PRE      = 2'd1,
    EVAL     = 2'd2
  } state_e;

  // Sticky error flags in err_out bit order (MSB first)
  typedef struct packed {
    logic overflow;
    logic prech_fault;
    logic eval_fault;
  } err_t;

endpackage

// File: rtl/wddl_decoder_if.sv
// Dual-rail input, single-rail valid/ready output and error reporting bundle.
interface wddl_decoder_if
  import wddl_decoder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) ();

  logic                 pre_in;
  logic [WIDTH-1:0]     d_p_in;
  logic [WIDTH-1:0]     d_n_in;
  logic [WIDTH-1:0]     d_out;
  logic                 d_valid_out;
  logic                 d_ready_in;
  logic [ERR_W-1:0]     err_out;
  logic [ERR_CNT_W-1:0] err_cnt_out;
  logic                 clr_err_in;

  modport slave (
    input  pre_in, d_p_in, d_n_in, d_ready_in, clr_err_in,
    output d_out, d_valid_out, err_out, err_cnt_out
  );

  modport master (
    output pre_in, d_p_in, d_n_in, d_ready_in, clr_err_in,
    input  d_out, d_valid_out, err_out, err_cnt_out
  );

endinterface

// File: rtl/wddl_rail_check.sv
// Combinational rail legality: all-precharged (both rails 0) and all-complementary.
module wddl_rail_check #(
  parameter int unsigned WIDTH = 128
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_all_zero_c,
  output logic             o_all_comp_c
);

  assign o_all_zero_c = ~|(i_p | i_n);
  assign o_all_comp_c = &(i_p ^ i_n);

endmodule

// File: rtl/wddl_decoder.sv
// WDDL-to-single-rail boundary: phase tracking, rail checks, 1-entry output
// buffer, sticky error flags and saturating error counter.
module wddl_decoder
  import wddl_decoder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  wddl_decoder_if.slave bus
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     r_p;
  logic [WIDTH-1:0]     r_n;
  logic                 r_pre;
  state_e               r_state;
  state_e               w_state_nxt;
  logic                 w_prech_end;
  logic                 w_eval_end;
  logic                 w_all_zero;
  logic                 w_all_comp;
  logic                 w_load;
  logic                 w_room;
  err_t                 w_evt;
  logic                 w_any_evt;
  logic [WIDTH-1:0]     r_d_out;
  logic                 r_valid;
  err_t                 r_err;
  logic [ERR_CNT_W-1:0] r_cnt;

  // Input stage, sampled every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p   <= '0;
      r_n   <= '0;
      r_pre <= 1'b0;
    end else begin
      r_p   <= bus.d_p_in;
      r_n   <= bus.d_n_in;
      r_pre <= bus.pre_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_PRE;
    else     r_state <= w_state_nxt;
  end

  // Phase edges are seen as registered phase vs. live pin
  always_comb begin
    w_state_nxt = r_state;
    w_prech_end = 1'b0;
    w_eval_end  = 1'b0;
    case (r_state)
      WAIT_PRE: begin
        if (r_pre) w_state_nxt = PRE;
      end
      PRE: begin
        if (r_pre && !bus.pre_in) begin
          w_state_nxt = EVAL;
          w_prech_end = 1'b1;
        end
      end
      EVAL: begin
        if (!r_pre && bus.pre_in) begin
          w_state_nxt = PRE;
          w_eval_end  = 1'b1;
        end
      end
      default: w_state_nxt = WAIT_PRE;
    endcase
  end

  wddl_rail_check #(.WIDTH(WIDTH)) u_rail_check (
    .i_p          (r_p),
    .i_n          (r_n),
    .o_all_zero_c (w_all_zero),
    .o_all_comp_c (w_all_comp)
  );

  assign w_load = w_eval_end & w_all_comp;
  assign w_room = ~r_valid | bus.d_ready_in;

  always_comb begin
    w_evt             = '0;
    w_evt.eval_fault  = w_eval_end & ~w_all_comp;
    w_evt.prech_fault = w_prech_end & ~w_all_zero;
    w_evt.overflow    = w_load & ~w_room;
  end

  assign w_any_evt = |w_evt;

  // One-entry output buffer; a blocked load is dropped and the held word kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_out <= '0;
      r_valid <= 1'b0;
    end else if (w_load && w_room) begin
      r_d_out <= r_p;
      r_valid <= 1'b1;
    end else if (r_valid && bus.d_ready_in) begin
      r_valid <= 1'b0;
    end
  end

  // A clear in the same cycle as an event keeps only that event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
      r_cnt <= '0;
    end else if (bus.clr_err_in) begin
      r_err <= w_evt;
      r_cnt <= w_any_evt ? ERR_CNT_W'(1) : '0;
    end else begin
      r_err <= err_t'(r_err | w_evt);
      if (w_any_evt && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.d_out       = r_d_out;
  assign bus.d_valid_out = r_valid;
  assign bus.err_out     = r_err;
  assign bus.err_cnt_out = r_cnt;

endmodule

// File: tb/tb_wddl_decoder.sv
// Self-checking bench: transaction-level WDDL stimulus against a behavioural model.
module tb_wddl_decoder;

  localparam int unsigned W  = 128;
  localparam int unsigned CW = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wddl_decoder_if #(.WIDTH(W), .ERR_CNT_W(CW)) bus ();
  wddl_decoder #(.WIDTH(W), .ERR_CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model of what the consumer should see
  logic         m_valid;
  logic [W-1:0] m_dout;
  logic [2:0]   m_err;
  int           m_cnt;
  // Outcome of a phase edge, applied at the clock ending the cycle it is posted in
  logic [2:0]   ev_next;
  logic         word_next;
  logic [W-1:0] word_val;

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".valid"}, W'(bus.d_valid_out), W'(m_valid));
    chk({ctx, ".d_out"}, bus.d_out, m_dout);
    chk({ctx, ".err"},   W'(bus.err_out), W'(m_err));
    chk({ctx, ".cnt"},   W'(bus.err_cnt_out), W'(m_cnt));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_dout = '0; m_err = '0; m_cnt = 0;
    ev_next = '0; word_next = 1'b0; word_val = '0;
  endtask

  task automatic step(input string ctx, input logic pre, input logic [W-1:0] p, input logic [W-1:0] n);
    logic [2:0] evt;
    bus.pre_in = pre; bus.d_p_in = p; bus.d_n_in = n;
    @(posedge clk);
    evt = ev_next;
    if (word_next) begin
      if (!m_valid || bus.d_ready_in) begin
        m_valid = 1'b1;
        m_dout  = word_val;
      end else begin
        evt[2] = 1'b1;
      end
    end else if (m_valid && bus.d_ready_in) begin
      m_valid = 1'b0;
    end
    if (bus.clr_err_in) begin
      m_err = evt;
      m_cnt = (evt != 3'b000) ? 1 : 0;
    end else begin
      m_err = m_err | evt;
      if (evt != 3'b000 && m_cnt < CNT_MAX) m_cnt++;
    end
    ev_next = '0; word_next = 1'b0;
    #1 check_all(ctx);
  endtask

  // One word: precharge (last sample pp/pn), evaluate (last sample ep/en), closing precharge
  task automatic txn(input string ctx, input int npre, input logic [W-1:0] pp, input logic [W-1:0] pn,
                     input int nev, input logic [W-1:0] ep, input logic [W-1:0] en,
                     input logic rdy_body, input logic rdy_close, input logic clr_close);
    logic [W-1:0] rw;
    rw = rnd();
    bus.d_ready_in = rdy_body;
    bus.clr_err_in = 1'b0;
    for (int i = 0; i < npre; i++)
      step(ctx, 1'b1, (i == npre - 1) ? pp : W'(0), (i == npre - 1) ? pn : W'(0));
    for (int i = 0; i < nev; i++) begin
      if (i == 0 && (pp | pn) != '0) ev_next[1] = 1'b1;
      if (i == nev - 1) step(ctx, 1'b0, ep, en);
      else              step(ctx, 1'b0, rw, ~rw);
    end
    if ((ep ^ en) != '1) ev_next[0] = 1'b1;
    else begin
      word_next = 1'b1;
      word_val  = ep;
    end
    bus.d_ready_in = rdy_close;
    bus.clr_err_in = clr_close;
    step(ctx, 1'b1, '0, '0);
    bus.clr_err_in = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b, bn, pp, pn;
    int           npre, nev;

    rst = 1'b1;
    bus.pre_in = 1'b0; bus.d_p_in = '0; bus.d_n_in = '0;
    bus.d_ready_in = 1'b1; bus.clr_err_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst = 1'b0;

    // Legal word with ready high: one-cycle valid, no errors
    a = {16{8'hA5}};
    txn("t1", 2, '0, '0, 2, a, ~a, 1'b1, 1'b1, 1'b0);
    chk("t1.word", bus.d_out, a);
    chk("t1.valid_on", W'(bus.d_valid_out), W'(1));
    step("t1.drop", 1'b1, '0, '0);
    chk("t1.valid_off", W'(bus.d_valid_out), W'(0));

    // Last evaluate sample with bit 3 on both rails
    b = rnd(); bn = ~b; b[3] = 1'b1; bn[3] = 1'b1;
    txn("t2", 2, '0, '0, 2, b, bn, 1'b1, 1'b1, 1'b0);
    chk("t2.cnt", W'(bus.err_cnt_out), W'(1));
    chk("t2.err", W'(bus.err_out), W'(3'b001));

    // Precharge fault on n[0]; word still delivered
    b = rnd();
    txn("t3", 2, '0, W'(1), 2, b, ~b, 1'b1, 1'b1, 1'b0);
    chk("t3.word", bus.d_out, b);
    chk("t3.err", W'(bus.err_out), W'(3'b011));

    // Clear without events
    bus.clr_err_in = 1'b1;
    step("clr", 1'b1, '0, '0);
    bus.clr_err_in = 1'b0;

    // Overflow: second word dropped while first is held
    a = rnd(); b = rnd();
    txn("t4a", 2, '0, '0, 2, a, ~a, 1'b0, 1'b0, 1'b0);
    txn("t4b", 2, '0, '0, 2, b, ~b, 1'b0, 1'b0, 1'b0);
    chk("t4.held", bus.d_out, a);
    chk("t4.ovf", W'(bus.err_out), W'(3'b100));
    bus.d_ready_in = 1'b1;
    step("t4.accept", 1'b1, '0, '0);
    step("t4.idle", 1'b1, '0, '0);

    // Accept and load in the same cycle
    a = rnd(); b = rnd();
    txn("t5a", 2, '0, '0, 2, a, ~a, 1'b0, 1'b0, 1'b0);
    txn("t5b", 2, '0, '0, 2, b, ~b, 1'b0, 1'b1, 1'b0);
    chk("t5.new", bus.d_out, b);
    step("t5.drop", 1'b1, '0, '0);

    // Single-cycle evaluate window
    a = rnd();
    txn("glitch", 2, '0, '0, 1, a, ~a, 1'b1, 1'b1, 1'b0);

    // Saturation, then clear with a concurrent fault
    b = '0;
    repeat (CNT_MAX + 2) txn("sat", 2, '0, '0, 1, b, b, 1'b1, 1'b1, 1'b0);
    chk("sat.cnt", W'(bus.err_cnt_out), W'(CNT_MAX));
    txn("clr_evt", 2, W'(4), '0, 1, b, b, 1'b1, 1'b1, 1'b1);
    chk("clr_evt.cnt", W'(bus.err_cnt_out), W'(1));
    chk("clr_evt.err", W'(bus.err_out), W'(3'b001));

    // Randomised traffic
    repeat (40) begin
      npre = $urandom_range(3, 2);
      nev  = $urandom_range(3, 1);
      pp = '0; pn = '0;
      if ($urandom_range(3, 0) == 0) pn[$urandom_range(W - 1, 0)] = 1'b1;
      a = rnd(); bn = ~a;
      if ($urandom_range(3, 0) == 0) bn[$urandom_range(W - 1, 0)] = a[0] ^ bn[0] ? ~bn[0] : bn[0];
      if ($urandom_range(3, 0) == 0) bn[$urandom_range(W - 1, 0)] ^= 1'b1;
      txn("rand", npre, pp, pn, nev, a, bn, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
          ($urandom_range(7, 0) == 0));
    end

    // Reset asserted mid-evaluate with a word pending in the buffer
    a = rnd();
    txn("pre_rst", 2, '0, '0, 2, a, ~a, 1'b0, 1'b0, 1'b0);
    step("mid", 1'b1, '0, '0);
    step("mid", 1'b1, '0, '0);
    step("mid", 1'b0, a, ~a);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    bus.d_ready_in = 1'b1;
    step("post_rst", 1'b0, a, ~a);
    step("post_rst", 1'b1, '0, '0);
    b = rnd();
    txn("post_rst_word", 2, '0, '0, 2, b, ~b, 1'b1, 1'b1, 1'b0);
    chk("post_rst.word", bus.d_out, b);
    step("post_rst.drop", 1'b1, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
